// File: rtl/alu_ctrl_pkg.sv
// Shared types and helpers for the ALU control-bus encoder.
// Op codes, bus widths, FSM state encoding and the op-to-one-hot mapping.
package alu_ctrl_pkg;

  localparam int CTRL_W = 8;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_SIGNED   = 4'd0;
  localparam logic [OP_W-1:0] OP_UNSIGNED = 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op[3] == 1'b0);
  endfunction

  // Code k in 0..7 drives bit (7-k) alone; illegal codes give an all-zero word.
  function automatic logic [CTRL_W-1:0] onehot_of(input logic [OP_W-1:0] op);
    logic [CTRL_W-1:0] word;
    case (op)
      4'd0:    word = 8'b1000_0000;
      4'd1:    word = 8'b0100_0000;
      4'd2:    word = 8'b0010_0000;
      4'd3:    word = 8'b0001_0000;
      4'd4:    word = 8'b0000_1000;
      4'd5:    word = 8'b0000_0100;
      4'd6:    word = 8'b0000_0010;
      4'd7:    word = 8'b0000_0001;
      default: word = 8'b0000_0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// Synchronous op FIFO, DEPTH x W, with extra-MSB pointers for full/empty.
// The head entry is read straight from the storage array (registered data).
module alu_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          do_push_s;
  logic          do_pop_s;
  logic          full_s;
  logic          empty_s;

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full_s;
  assign do_pop_s  = pop && !empty_s;

  assign head  = mem_r[rd_ptr_r[AW-1:0]];
  assign full  = full_s;
  assign empty = empty_s;

  // Read/write pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/alu_ctrl_encoder.sv
// Drives the ALU one-hot Control bus from queued 4-bit op codes, holding each
// word for HOLD_CYCLES cycles. Define ALU_ENC_CNT_EN to add the issued_cnt port.
module alu_ctrl_encoder
  import alu_ctrl_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   op_code,
  output logic              op_ready,
  output logic [CTRL_W-1:0] Control,
  output logic              ctrl_strobe,
  output logic              op_done,
  output logic              op_err,
  output logic              busy
`ifdef ALU_ENC_CNT_EN
  ,
  output logic [CNT_W-1:0]  issued_cnt
`endif
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] CNT_ZERO  = '0;
  localparam logic [HC_W-1:0] CNT_ONE   = HC_W'(1);
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
  localparam logic            HOLD_ONE  = (HOLD_CYCLES == 1);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      HOLD_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("alu_ctrl_encoder: unsupported parameter set");
  end

  state_t            state_r, state_n;
  logic [CTRL_W-1:0] ctrl_r, ctrl_n;
  logic [HC_W-1:0]   cnt_r, cnt_n;
  logic              strobe_r, strobe_n;
  logic              done_r, done_n;
  logic              err_r, err_n;

  logic [OP_W-1:0]   head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              last_s;
  logic              advance_s;

  alu_op_fifo #(
    .DEPTH (DEPTH),
    .W     (OP_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (op_valid),
    .pop   (advance_s),
    .din   (op_code),
    .head  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Last hold cycle of a legal op; an illegal op in LOAD carries a zero word.
  assign last_s    = (state_r != IDLE) && (cnt_r == CNT_ZERO) && (ctrl_r != '0);
  assign advance_s = ((state_r == IDLE) || last_s) && !fifo_empty_s;

  // Next-state and next-output logic; popping reloads Control with no gap.
  always_comb begin
    state_n  = state_r;
    ctrl_n   = ctrl_r;
    cnt_n    = cnt_r;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    if (advance_s) begin
      state_n = LOAD;
      if (op_is_legal(head_s)) begin
        ctrl_n   = onehot_of(head_s);
        cnt_n    = HOLD_LOAD;
        strobe_n = 1'b1;
        done_n   = HOLD_ONE;
      end else begin
        ctrl_n = '0;
        cnt_n  = CNT_ZERO;
        err_n  = 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          ctrl_n = '0;
          cnt_n  = CNT_ZERO;
        end
        LOAD, HOLD: begin
          if ((ctrl_r == '0) || (cnt_r == CNT_ZERO)) begin
            state_n = IDLE;
            ctrl_n  = '0;
            cnt_n   = CNT_ZERO;
          end else begin
            state_n = HOLD;
            cnt_n   = cnt_r - CNT_ONE;
            done_n  = (cnt_r == CNT_ONE);
          end
        end
        default: begin
          state_n = IDLE;
          ctrl_n  = '0;
          cnt_n   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ctrl_r   <= '0;
      cnt_r    <= CNT_ZERO;
      strobe_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_n;
      ctrl_r   <= ctrl_n;
      cnt_r    <= cnt_n;
      strobe_r <= strobe_n;
      done_r   <= done_n;
      err_r    <= err_n;
    end
  end

  assign Control     = ctrl_r;
  assign ctrl_strobe = strobe_r;
  assign op_done     = done_r;
  assign op_err      = err_r;
  assign op_ready    = !fifo_full_s;
  assign busy        = (state_r != IDLE) || !fifo_empty_s;

`ifdef ALU_ENC_CNT_EN
  logic [CNT_W-1:0] issued_r;

  // Counts legal ops, updating on the edge that raises ctrl_strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_r <= '0;
    end else if (strobe_n) begin
      issued_r <= issued_r + CNT_W'(1);
    end
  end

  assign issued_cnt = issued_r;
`endif

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// Directed bench for alu_ctrl_encoder (DEPTH=4, HOLD_CYCLES=3, CNT_W=2).
module tb_alu_ctrl_encoder;
  import alu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [3:0] op_code = 4'd0;
  logic       op_ready;
  logic [7:0] Control;
  logic       ctrl_strobe;
  logic       op_done;
  logic       op_err;
  logic       busy;
`ifdef ALU_ENC_CNT_EN
  logic [1:0] issued_cnt;
`endif

  alu_ctrl_encoder #(
    .DEPTH       (4),
    .HOLD_CYCLES (3),
    .CNT_W       (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_ready    (op_ready),
    .Control     (Control),
    .ctrl_strobe (ctrl_strobe),
    .op_done     (op_done),
    .op_err      (op_err),
    .busy        (busy)
`ifdef ALU_ENC_CNT_EN
    ,
    .issued_cnt  (issued_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor: words seen on strobes, done and error pulse counts.
  logic [7:0] strobe_q[$];
  int         done_cnt = 0;
  int         err_cnt  = 0;
  always @(negedge clk) begin
    if (ctrl_strobe) strobe_q.push_back(Control);
    if (op_done) done_cnt++;
    if (op_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] samp [11];
  logic [7:0] exp2 [11];
  logic [3:0] codes [6];
  logic [7:0] exp3 [7];
  logic       rdy_tr [12];
  int         acc [6];
  int         n_acc;
  int         sb;
  int         bd;
  int         be;
  logic       found;
`ifdef ALU_ENC_CNT_EN
  logic [1:0] cnt_before;
  logic [1:0] exp6 [5];
`endif

  initial begin
    exp2 = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h00};
    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    exp3 = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04};

    // Reset values
    #12;
    chk("rst_control", 32'(Control), 32'h00);
    chk("rst_strobe", 32'(ctrl_strobe), 32'd0);
    chk("rst_done", 32'(op_done), 32'd0);
    chk("rst_err", 32'(op_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(op_ready), 32'd1);
`ifdef ALU_ENC_CNT_EN
    chk("rst_issued", 32'(issued_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Single op: 2-cycle latency, 3-cycle hold
    op_valid = 1'b1; op_code = OP_SIGNED;
    step();
    op_valid = 1'b0;
    chk("t1_c1_control", 32'(Control), 32'h00);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    step();
    chk("t1_c2_control", 32'(Control), 32'h80);
    chk("t1_c2_strobe", 32'(ctrl_strobe), 32'd1);
    chk("t1_c2_done", 32'(op_done), 32'd0);
    step();
    chk("t1_c3_control", 32'(Control), 32'h80);
    chk("t1_c3_strobe", 32'(ctrl_strobe), 32'd0);
    chk("t1_c3_done", 32'(op_done), 32'd0);
    step();
    chk("t1_c4_control", 32'(Control), 32'h80);
    chk("t1_c4_done", 32'(op_done), 32'd1);
    step();
    chk("t1_c5_control", 32'(Control), 32'h00);
    chk("t1_c5_done", 32'(op_done), 32'd0);
    chk("t1_c5_busy", 32'(busy), 32'd0);

    // Back-to-back ops 0,1,0
    bd = done_cnt;
    op_valid = 1'b1; op_code = OP_SIGNED;
    step(); samp[0] = Control;
    op_code = OP_UNSIGNED;
    step(); samp[1] = Control;
    op_code = OP_SIGNED;
    step(); samp[2] = Control;
    op_valid = 1'b0;
    for (int i = 3; i < 11; i++) begin
      step();
      samp[i] = Control;
    end
    for (int i = 0; i < 11; i++) chk($sformatf("t2_control_c%0d", i + 1), 32'(samp[i]), 32'(exp2[i]));
    chk("t2_done_pulses", 32'(done_cnt - bd), 32'd3);

    // Fill the FIFO behind a held op; op_valid stays high
    sb = strobe_q.size();
    bd = done_cnt;
    op_valid = 1'b1; op_code = 4'd7;
    step();
    op_valid = 1'b0;
    step();
    op_valid = 1'b1; op_code = codes[0]; n_acc = 0;
    for (int c = 2; c < 12; c++) begin
      rdy_tr[c] = op_ready;
      step();
      if (op_valid && rdy_tr[c]) begin
        acc[n_acc] = c;
        n_acc++;
        if (n_acc < 6) op_code = codes[n_acc];
        else op_valid = 1'b0;
      end
    end
    chk("t3_accepted", 32'(n_acc), 32'd6);
    chk("t3_acc4_edge", 32'(acc[3]), 32'd5);
    chk("t3_acc5_edge", 32'(acc[4]), 32'd6);
    chk("t3_acc6_edge", 32'(acc[5]), 32'd8);
    chk("t3_ready_c6", 32'(rdy_tr[6]), 32'd1);
    chk("t3_ready_c7_full", 32'(rdy_tr[7]), 32'd0);
    chk("t3_ready_c8", 32'(rdy_tr[8]), 32'd1);
    chk("t3_ready_c9_full", 32'(rdy_tr[9]), 32'd0);
    for (int k = 0; k < 60 && busy; k++) step();
    chk("t3_drain_busy", 32'(busy), 32'd0);
    chk("t3_strobe_count", 32'(strobe_q.size() - sb), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (sb + i < strobe_q.size())
        chk($sformatf("t3_word%0d", i), 32'(strobe_q[sb + i]), 32'(exp3[i]));
      else
        chk($sformatf("t3_word%0d_missing", i), 32'hFFFF_FFFF, 32'(exp3[i]));
    end
    chk("t3_done_pulses", 32'(done_cnt - bd), 32'd7);

    // Illegal op 9
    bd = done_cnt; be = err_cnt; sb = strobe_q.size();
`ifdef ALU_ENC_CNT_EN
    cnt_before = issued_cnt;
`endif
    op_valid = 1'b1; op_code = 4'd9;
    step();
    op_valid = 1'b0;
    chk("t4_c1_control", 32'(Control), 32'h00);
    step();
    chk("t4_c2_err", 32'(op_err), 32'd1);
    chk("t4_c2_control", 32'(Control), 32'h00);
    chk("t4_c2_strobe", 32'(ctrl_strobe), 32'd0);
    step();
    chk("t4_c3_err", 32'(op_err), 32'd0);
    chk("t4_c3_busy", 32'(busy), 32'd0);
    step();
    chk("t4_err_pulses", 32'(err_cnt - be), 32'd1);
    chk("t4_done_pulses", 32'(done_cnt - bd), 32'd0);
    chk("t4_no_strobe", 32'(strobe_q.size() - sb), 32'd0);
`ifdef ALU_ENC_CNT_EN
    chk("t4_issued_same", 32'(issued_cnt), 32'(cnt_before));
`endif

    // Reset during HOLD with two ops queued
    op_valid = 1'b1; op_code = OP_SIGNED;
    step();
    op_code = OP_UNSIGNED;
    step();
    op_code = 4'd2;
    step();
    op_valid = 1'b0;
    chk("t5_hold_control", 32'(Control), 32'h80);
    chk("t5_hold_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_control", 32'(Control), 32'h00);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb = strobe_q.size();
    for (int k = 0; k < 10; k++) step();
    chk("t5_no_issue", 32'(strobe_q.size() - sb), 32'd0);
    chk("t5_after_control", 32'(Control), 32'h00);
    chk("t5_after_busy", 32'(busy), 32'd0);

`ifdef ALU_ENC_CNT_EN
    // Counter wrap with CNT_W = 2
    exp6 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    chk("t6_start", 32'(issued_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      op_valid = 1'b1;
      op_code = (i % 2 == 1) ? OP_UNSIGNED : OP_SIGNED;
      step();
      op_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        step();
        if (ctrl_strobe) found = 1'b1;
      end
      chk($sformatf("t6_strobe%0d_seen", i), 32'(found), 32'd1);
      chk($sformatf("t6_issued%0d", i), 32'(issued_cnt), 32'(exp6[i]));
    end
    for (int k = 0; k < 20 && busy; k++) step();
    chk("t6_drain_busy", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
